// File: rtl/adder_tree_pipe_pkg.sv
// rtl/adder_tree_pipe_pkg.sv - shared constants and helpers for the adder tree
//
// Purpose: lane-sign encoding constants and a constant log2 helper used to
// size the tree depth.
// Ports: none (package).
package adder_tree_pipe_pkg;

  // Lane interpretation selected by the SIGNED parameter.
  localparam int SIGN_UNSIGNED = 0;
  localparam int SIGN_TWOS     = 1;

  // Ceiling log2 for elaboration-time sizing; N_IN is a power of two so this
  // is the exact tree depth.
  function automatic int clog2_f(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) begin
      if ((1 << i) < v) r = i + 1;
    end
    return r;
  endfunction

endpackage

// File: rtl/adder_tree_level.sv
// rtl/adder_tree_level.sv - one registered pairwise-add level of the reduction tree
//
// Purpose: adds adjacent lane pairs (2i, 2i+1), growing each sum by one bit so
// the level cannot overflow. Data loads only on a valid beat; valid/last
// always shift so bubbles propagate.
// Ports:
//   clk, reset           - clock, asynchronous active-high reset
//   in_valid, in_last    - beat qualifiers from the previous level
//   in_data              - 2*N_PAIRS lanes of W bits
//   out_valid, out_last  - registered qualifiers
//   out_data             - N_PAIRS lanes of W+1 bits
module adder_tree_level
  import adder_tree_pipe_pkg::*;
#(
  parameter int N_PAIRS = 1,
  parameter int W       = 16,
  parameter int SIGNED  = 1
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     in_valid,
  input  logic                     in_last,
  input  logic [2*N_PAIRS*W-1:0]   in_data,
  output logic                     out_valid,
  output logic                     out_last,
  output logic [N_PAIRS*(W+1)-1:0] out_data
);

  logic [N_PAIRS*(W+1)-1:0] sum_d;
  logic [N_PAIRS*(W+1)-1:0] sum_q;
  logic                     valid_q;
  logic                     last_q;

  always_comb begin
    sum_d = '0;
    for (int i = 0; i < N_PAIRS; i++) begin
      logic [W-1:0] a;
      logic [W-1:0] b;
      logic [W:0]   a_x;
      logic [W:0]   b_x;
      a = in_data[(2*i)*W +: W];
      b = in_data[(2*i+1)*W +: W];
      if (SIGNED == SIGN_TWOS) begin
        a_x = {a[W-1], a};
        b_x = {b[W-1], b};
      end else begin
        a_x = {1'b0, a};
        b_x = {1'b0, b};
      end
      sum_d[i*(W+1) +: (W+1)] = a_x + b_x;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sum_q   <= '0;
      valid_q <= 1'b0;
      last_q  <= 1'b0;
    end else begin
      valid_q <= in_valid;
      last_q  <= in_last;
      if (in_valid) sum_q <= sum_d;
    end
  end

  assign out_valid = valid_q;
  assign out_last  = last_q;
  assign out_data  = sum_q;

endmodule

// File: rtl/adder_tree_pipe.sv
// rtl/adder_tree_pipe.sv - pipelined N_IN-lane reduction tree with group accumulator
//
// Purpose: log2(N_IN) registered add levels reduce all lanes to one sum, then a
// streaming accumulator sums beats until a last beat and emits the group sum.
// Optional macro ADDER_TREE_SAT_EN: clamp the accumulator on overflow instead
// of wrapping; out_ovf reports either way.
// Ports:
//   clk, reset            - clock, asynchronous active-high reset
//   in_valid, in_last     - beat valid, final beat of group (qualified by valid)
//   in_data               - N_IN packed lanes, lane k at [k*IN_W +: IN_W]
//   out_valid             - one-cycle pulse with a completed group
//   out_sum, out_ovf      - group sum and sticky overflow, held until next pulse
module adder_tree_pipe
  import adder_tree_pipe_pkg::*;
#(
  parameter int N_IN   = 16,
  parameter int IN_W   = 16,
  parameter int ACC_W  = 32,
  parameter int SIGNED = 1
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 in_valid,
  input  logic [N_IN*IN_W-1:0] in_data,
  input  logic                 in_last,
  output logic                 out_valid,
  output logic [ACC_W-1:0]     out_sum,
  output logic                 out_ovf
);

  localparam int L  = clog2_f(N_IN);
  localparam int TW = IN_W + L;

  genvar j;
  generate
    for (j = 1; j <= L; j++) begin : g_lvl
      localparam int NP = N_IN >> j;
      localparam int WI = IN_W + j - 1;
      logic [2*NP*WI-1:0]   din;
      logic                 vin;
      logic                 lin;
      logic [NP*(WI+1)-1:0] dout;
      logic                 vout;
      logic                 lout;
      if (j == 1) begin : g_first
        assign din = in_data;
        assign vin = in_valid;
        // last only means something on a valid beat
        assign lin = in_last & in_valid;
      end else begin : g_next
        assign din = g_lvl[j-1].dout;
        assign vin = g_lvl[j-1].vout;
        assign lin = g_lvl[j-1].lout;
      end
      adder_tree_level #(
        .N_PAIRS(NP),
        .W      (WI),
        .SIGNED (SIGNED)
      ) u_level (
        .clk      (clk),
        .reset    (reset),
        .in_valid (vin),
        .in_last  (lin),
        .in_data  (din),
        .out_valid(vout),
        .out_last (lout),
        .out_data (dout)
      );
    end
  endgenerate

  logic [TW-1:0]    tree_sum;
  logic             tree_valid;
  logic             tree_last;
  logic [ACC_W-1:0] tree_ext;

  assign tree_sum   = g_lvl[L].dout;
  assign tree_valid = g_lvl[L].vout;
  assign tree_last  = g_lvl[L].lout;

  logic [ACC_W-1:0] acc_q;
  logic             ovf_q;
  logic             first_q;
  logic             out_valid_q;
  logic [ACC_W-1:0] out_sum_q;
  logic             out_ovf_q;

  logic [ACC_W:0]   add_full;
  logic             step_ovf;
  logic [ACC_W-1:0] acc_d;
  logic             ovf_d;
`ifdef ADDER_TREE_SAT_EN
  logic [ACC_W-1:0] clamp_val;
`endif

  always_comb begin
    tree_ext = '0;
    if (SIGNED == SIGN_TWOS) tree_ext = ACC_W'($signed(tree_sum));
    else                     tree_ext = ACC_W'(tree_sum);

    add_full = {1'b0, acc_q} + {1'b0, tree_ext};
    if (SIGNED == SIGN_TWOS)
      step_ovf = (acc_q[ACC_W-1] == tree_ext[ACC_W-1]) &&
                 (add_full[ACC_W-1] != acc_q[ACC_W-1]);
    else
      step_ovf = add_full[ACC_W];

`ifdef ADDER_TREE_SAT_EN
    // Overflow direction follows the operands' common sign.
    if (SIGNED == SIGN_TWOS)
      clamp_val = acc_q[ACC_W-1] ? {1'b1, {(ACC_W-1){1'b0}}}
                                 : {1'b0, {(ACC_W-1){1'b1}}};
    else
      clamp_val = '1;
`endif

    if (first_q) begin
      // First beat of a group cannot overflow since ACC_W >= TW.
      acc_d = tree_ext;
      ovf_d = 1'b0;
    end else begin
`ifdef ADDER_TREE_SAT_EN
      acc_d = step_ovf ? clamp_val : add_full[ACC_W-1:0];
`else
      acc_d = add_full[ACC_W-1:0];
`endif
      ovf_d = ovf_q | step_ovf;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc_q       <= '0;
      ovf_q       <= 1'b0;
      first_q     <= 1'b1;
      out_valid_q <= 1'b0;
      out_sum_q   <= '0;
      out_ovf_q   <= 1'b0;
    end else begin
      out_valid_q <= 1'b0;
      if (tree_valid) begin
        acc_q <= acc_d;
        ovf_q <= ovf_d;
        if (tree_last) begin
          first_q     <= 1'b1;
          out_valid_q <= 1'b1;
          out_sum_q   <= acc_d;
          out_ovf_q   <= ovf_d;
        end else begin
          first_q <= 1'b0;
        end
      end
    end
  end

  assign out_valid = out_valid_q;
  assign out_sum   = out_sum_q;
  assign out_ovf   = out_ovf_q;

endmodule

// File: doc/adder_tree_pipe.md
Name: adder_tree_pipe

Overview:
- Parametrised, fully pipelined reduction tree. Sums N_IN packed lanes into one value, one register level per tree level.
- A streaming accumulator follows the tree and sums successive valid beats until a beat marked in_last arrives.
- Generalises the fixed 16-to-8 single-level stage into a complete multi-level dot-product back end between the multiplier array and the output/activation logic.

Parameters:
- N_IN, 16, number of input lanes; power of two, >= 2.
- IN_W, 16, width of each lane.
- ACC_W, 32, accumulator/output width; must be >= IN_W + log2(N_IN).
- SIGNED, 1, 1 = lanes are two's complement (sign-extend); 0 = unsigned (zero-extend).

Ports:
- clk, input, 1, clock; all state updates on the rising edge.
- reset, input, 1, asynchronous, active-high; clears all state.
- in_valid, input, 1, in_data/in_last are valid this cycle.
- in_data, input, N_IN*IN_W, packed lanes; lane k is bits [k*IN_W +: IN_W].
- in_last, input, 1, final beat of the current accumulation group; qualified by in_valid.
- out_valid, output, 1, single-cycle pulse; out_sum holds a completed group sum.
- out_sum, output, ACC_W, accumulated group sum.
- out_ovf, output, 1, set with out_valid if any accumulation step in the group overflowed ACC_W.

Behaviour:
- Levels: L = log2(N_IN).
  - Level j (1..L) holds N_IN/2^j registered partial sums of width IN_W+j.
  - Partial sum i of level j = extend(pair 2i) + extend(pair 2i+1) from level j-1. Level 0 is in_data.
  - Extension is sign or zero per SIGNED. No truncation inside the tree, so the tree itself never overflows.
- Valid pipeline:
  - A valid bit and a last bit travel alongside each level.
  - A level's data registers load only when its incoming valid is 1; otherwise they hold.
  - Valid/last always shift, so bubbles (in_valid=0) propagate as bubbles.
- Accumulator stage, on a cycle where the tree output is valid:
  - If first_beat=1: acc <= ext(tree_sum).
  - Otherwise: acc <= acc + ext(tree_sum).
  - first_beat is set at reset and after every last beat; it is cleared by any non-last valid beat.
  - Overflow is detected per add (signed: operand signs equal and result sign differs; unsigned: carry out). It is ORed into a sticky ovf flag that is reset at the group start.
- Output:
  - When a valid beat with last=1 reaches the accumulator: out_valid=1 next cycle, out_sum = final acc, out_ovf = sticky flag including this beat.
  - out_sum/out_ovf hold until the next out_valid.
- Latency: in_valid&in_last at cycle t -> out_valid at t+L+1.
- Throughput: one beat per cycle, no backpressure. The consumer must always accept out_valid.
- Single-beat group (in_valid & in_last with first_beat=1): out_sum = that beat's tree sum.
- Group of zero valid beats: not possible, since in_last without in_valid is ignored.
- Reset values: out_valid=0, out_sum=0, out_ovf=0, all level valid/last bits=0, acc=0, ovf=0, first_beat=1. Partial-sum registers = 0.
- Reset mid-group: the partial group is discarded and no out_valid is produced. The first valid beat after reset starts a new group.
- Without saturation: the accumulator wraps modulo 2^ACC_W.

Optional Feature:
- ADDER_TREE_SAT_EN defined:
  - On overflow the accumulator clamps to max/min representable per SIGNED: signed 2^(ACC_W-1)-1 / -2^(ACC_W-1); unsigned 2^ACC_W-1.
  - It stays clamped until further adds bring it back in range.
  - out_ovf still reports.
- Not defined: wrap-around arithmetic, out_ovf still reports.

Decomposition:
- Shared header (def.v):
  - a log2 constant function;
  - lane-slice macros generalised by parameter;
  - the SIGNED encoding constants.
- One sub-module, adder_tree_level:
  - parameters N_PAIRS and W;
  - registered pairwise adder with its valid/last shift and load enable;
  - instantiated L times via generate.
- Accumulator, overflow and first_beat logic stay in the top module.

Test Plan (all with N_IN=16, IN_W=16, ACC_W=32 unless noted):
- Single beat: all lanes 1, in_last=1, SIGNED=1 -> out_valid exactly 5 cycles later, out_sum=16, out_ovf=0.
- Signed extension: lanes alternate 16'h8000 and 16'h7FFF, 3-beat group -> out_sum = 3*8*(-1) = -24 (32'hFFFFFFE8). Same data with SIGNED=0 -> 3*8*65535 = 1572840.
- Bubbles and back-to-back groups:
  - beats A(last) and B(last) on consecutive cycles, then a gap, then C, bubble, D(last);
  - required: three out_valid pulses with sums A, B, C+D, and no merging across groups.
- Overflow (ACC_W=20, SIGNED=1): lanes all 16'h7FFF, 2-beat group.
  - Without macro: wrapped value and out_ovf=1.
  - With ADDER_TREE_SAT_EN: out_sum=20'h7FFFF and out_ovf=1.
- Reset mid-group: 2 non-last beats, assert reset for 1 cycle, then 1 beat of all lanes 2 with in_last -> exactly one out_valid with out_sum=32, and no stale contribution.
- Random regression: 10k random beats with random in_last/in_valid compared against a reference-model sum, checking latency and every out_valid.
